// File: rtl/bpu_bimodal_btb_pkg.sv
// ============================================================================
// Module      : bpu_bimodal_btb_pkg
// Description : Shared defaults and types for the bimodal/gshare BTB predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpu_bimodal_btb_pkg;

    localparam int unsigned BPU_PC_W      = 32;
    localparam int unsigned BPU_ENTRIES   = 64;
    localparam int unsigned BPU_TAG_W     = 8;
    localparam int unsigned BPU_CTR_W     = 2;
    localparam int unsigned BPU_CTR_INIT  = 1;
    localparam int unsigned BPU_GHR_W     = 6;
    localparam int unsigned BPU_NUM_SLOTS = 2;

    typedef enum logic [0:0] {
        PHT_IDX_PC     = 1'b0,
        PHT_IDX_GSHARE = 1'b1
    } pht_idx_mode_e;

endpackage : bpu_bimodal_btb_pkg

`default_nettype wire

// File: rtl/bpu_sat_ctr_next.sv
// ============================================================================
// Module      : bpu_sat_ctr_next
// Description : Combinational next value of a CTR_W-bit saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpu_sat_ctr_next #(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);

    localparam logic [CTR_W-1:0] c_ctr_max = '1;
    localparam logic [CTR_W-1:0] c_ctr_min = '0;
    localparam logic [CTR_W-1:0] c_ctr_one = CTR_W'(1);

    always_comb begin
        nxt = cur;
        if (taken) begin
            if (cur != c_ctr_max) begin
                nxt = cur + c_ctr_one;
            end
        end else if (cur != c_ctr_min) begin
            nxt = cur - c_ctr_one;
        end
    end

endmodule : bpu_sat_ctr_next

`default_nettype wire

// File: rtl/bpu_bimodal_btb.sv
// ============================================================================
// Module      : bpu_bimodal_btb
// Description : Direct-mapped BTB plus PHT of saturating counters, two
//               combinational lookup ports, trained from EX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpu_bimodal_btb
    import bpu_bimodal_btb_pkg::*;
#(
    parameter int unsigned PC_W     = BPU_PC_W,
    parameter int unsigned ENTRIES  = BPU_ENTRIES,
    parameter int unsigned TAG_W    = BPU_TAG_W,
    parameter int unsigned CTR_W    = BPU_CTR_W,
    parameter int unsigned CTR_INIT = BPU_CTR_INIT,
    parameter int unsigned GSHARE   = 0,
    parameter int unsigned GHR_W    = BPU_GHR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lk0_pc,
    output logic             lk0_hit,
    output logic             lk0_taken,
    output logic [PC_W-1:0]  lk0_target,
    input  logic [PC_W-1:0]  lk1_pc,
    output logic             lk1_hit,
    output logic             lk1_taken,
    output logic [PC_W-1:0]  lk1_target,
    output logic [GHR_W-1:0] ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             inv_all
);

    localparam int unsigned      c_idx_w    = $clog2(ENTRIES);
    localparam int unsigned      c_tag_lo   = c_idx_w + 2;
    localparam int unsigned      c_tag_hi   = c_idx_w + TAG_W + 1;
    localparam logic [CTR_W-1:0] c_ctr_init = CTR_W'(CTR_INIT);
    localparam pht_idx_mode_e    c_idx_mode = (GSHARE != 0) ? PHT_IDX_GSHARE : PHT_IDX_PC;

    logic                  r_valid_q  [ENTRIES];
    logic                  w_valid_d  [ENTRIES];
    logic [TAG_W-1:0]      r_tag_q    [ENTRIES];
    logic [TAG_W-1:0]      w_tag_d    [ENTRIES];
    logic [PC_W-1:0]       r_target_q [ENTRIES];
    logic [PC_W-1:0]       w_target_d [ENTRIES];
    logic                  r_jump_q   [ENTRIES];
    logic                  w_jump_d   [ENTRIES];
    logic [CTR_W-1:0]      r_pht_q    [ENTRIES];
    logic [CTR_W-1:0]      w_pht_d    [ENTRIES];
    logic [GHR_W-1:0]      r_ghr_q;
    logic [GHR_W-1:0]      w_ghr_d;
    logic [GHR_W-1:0]      w_ghr_shift;

    logic [PC_W-1:0]       w_lk_pc     [BPU_NUM_SLOTS];
    logic                  w_lk_hit    [BPU_NUM_SLOTS];
    logic                  w_lk_taken  [BPU_NUM_SLOTS];
    logic [PC_W-1:0]       w_lk_target [BPU_NUM_SLOTS];

    logic [c_idx_w-1:0]    w_upd_idx;
    logic [c_idx_w-1:0]    w_upd_pidx;
    logic [TAG_W-1:0]      w_upd_tag;
    logic [CTR_W-1:0]      w_upd_ctr_nxt;
    logic                  w_pht_we;
    logic                  w_btb_we;
    logic                  w_unused_bits;

    assign w_lk_pc[0] = lk0_pc;
    assign w_lk_pc[1] = lk1_pc;

    // Only the index and tag fields of each PC feed the tables
    assign w_unused_bits = ^{lk0_pc, lk1_pc, upd_pc, upd_ghr};

    for (genvar s = 0; s < BPU_NUM_SLOTS; s++) begin : g_lookup
        logic [c_idx_w-1:0] w_idx;
        logic [c_idx_w-1:0] w_pidx;
        logic [TAG_W-1:0]   w_tag;

        assign w_idx = w_lk_pc[s][c_idx_w+1:2];
        assign w_tag = w_lk_pc[s][c_tag_hi:c_tag_lo];

        if (c_idx_mode == PHT_IDX_GSHARE) begin : g_gshare
            assign w_pidx = w_idx ^ c_idx_w'(r_ghr_q);
        end else begin : g_bimodal
            assign w_pidx = w_idx;
        end

        assign w_lk_hit[s]    = r_valid_q[w_idx] && (r_tag_q[w_idx] == w_tag);
        assign w_lk_taken[s]  = w_lk_hit[s] && (r_jump_q[w_idx] || r_pht_q[w_pidx][CTR_W-1]);
        assign w_lk_target[s] = w_lk_hit[s] ? r_target_q[w_idx] : '0;
    end

    assign lk0_hit    = w_lk_hit[0];
    assign lk0_taken  = w_lk_taken[0];
    assign lk0_target = w_lk_target[0];
    assign lk1_hit    = w_lk_hit[1];
    assign lk1_taken  = w_lk_taken[1];
    assign lk1_target = w_lk_target[1];
    assign ghr        = r_ghr_q;

    assign w_upd_idx = upd_pc[c_idx_w+1:2];
    assign w_upd_tag = upd_pc[c_tag_hi:c_tag_lo];

    // Training uses the history seen at lookup time, not the current one
    if (c_idx_mode == PHT_IDX_GSHARE) begin : g_upd_gshare
        assign w_upd_pidx = w_upd_idx ^ c_idx_w'(upd_ghr);
    end else begin : g_upd_bimodal
        assign w_upd_pidx = w_upd_idx;
    end

    if (GHR_W == 1) begin : g_ghr_w1
        assign w_ghr_shift = upd_taken;
    end else begin : g_ghr_wn
        assign w_ghr_shift = {r_ghr_q[GHR_W-2:0], upd_taken};
    end

    assign w_pht_we = upd_valid && !upd_is_jump;
    assign w_btb_we = upd_valid && upd_taken && !inv_all;

    bpu_sat_ctr_next #(
        .CTR_W (CTR_W)
    ) u_sat_ctr (
        .cur   (r_pht_q[w_upd_pidx]),
        .taken (upd_taken),
        .nxt   (w_upd_ctr_nxt)
    );

    always_comb begin
        w_valid_d  = r_valid_q;
        w_tag_d    = r_tag_q;
        w_target_d = r_target_q;
        w_jump_d   = r_jump_q;
        w_pht_d    = r_pht_q;
        w_ghr_d    = r_ghr_q;

        if (w_pht_we) begin
            w_pht_d[w_upd_pidx] = w_upd_ctr_nxt;
            w_ghr_d             = w_ghr_shift;
        end

        if (inv_all) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                w_valid_d[i] = 1'b0;
            end
        end

        // Not-taken outcomes never allocate; taken ones replace whatever is there
        if (w_btb_we) begin
            w_valid_d[w_upd_idx]  = 1'b1;
            w_tag_d[w_upd_idx]    = w_upd_tag;
            w_target_d[w_upd_idx] = upd_target;
            w_jump_d[w_upd_idx]   = upd_is_jump;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid_q[i] <= 1'b0;
                r_pht_q[i]   <= c_ctr_init;
            end
            r_ghr_q <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_pht_q   <= w_pht_d;
            r_ghr_q   <= w_ghr_d;
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        r_tag_q    <= w_tag_d;
        r_target_q <= w_target_d;
        r_jump_q   <= w_jump_d;
    end

endmodule : bpu_bimodal_btb

`default_nettype wire

// File: tb/tb_bpu_bimodal_btb.sv
// ============================================================================
// Module      : tb_bpu_bimodal_btb
// Description : Scoreboard bench for bpu_bimodal_btb, bimodal and gshare modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bpu_bimodal_btb;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Bimodal instance
    logic [31:0] lk0_pc, lk1_pc, lk0_target, lk1_target, upd_pc, upd_target;
    logic        lk0_hit, lk0_taken, lk1_hit, lk1_taken;
    logic        upd_valid, upd_is_jump, upd_taken, inv_all;
    logic [5:0]  ghr, upd_ghr;

    // Gshare instance
    logic [31:0] g_lk0_pc, g_lk1_pc, g_lk0_target, g_lk1_target, g_upd_pc, g_upd_target;
    logic        g_lk0_hit, g_lk0_taken, g_lk1_hit, g_lk1_taken;
    logic        g_upd_valid, g_upd_is_jump, g_upd_taken, g_inv_all;
    logic [5:0]  g_ghr, g_upd_ghr;

    bpu_bimodal_btb #(.GSHARE(0)) dut (
        .clk(clk), .rst(rst),
        .lk0_pc(lk0_pc), .lk0_hit(lk0_hit), .lk0_taken(lk0_taken), .lk0_target(lk0_target),
        .lk1_pc(lk1_pc), .lk1_hit(lk1_hit), .lk1_taken(lk1_taken), .lk1_target(lk1_target),
        .ghr(ghr), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_ghr(upd_ghr), .inv_all(inv_all)
    );

    bpu_bimodal_btb #(.GSHARE(1)) dut_g (
        .clk(clk), .rst(rst),
        .lk0_pc(g_lk0_pc), .lk0_hit(g_lk0_hit), .lk0_taken(g_lk0_taken), .lk0_target(g_lk0_target),
        .lk1_pc(g_lk1_pc), .lk1_hit(g_lk1_hit), .lk1_taken(g_lk1_taken), .lk1_target(g_lk1_target),
        .ghr(g_ghr), .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_is_jump(g_upd_is_jump),
        .upd_taken(g_upd_taken), .upd_target(g_upd_target), .upd_ghr(g_upd_ghr), .inv_all(g_inv_all)
    );

    typedef struct {
        bit          sel;
        logic        h0, t0;
        logic [31:0] a0;
        logic        h1, t1;
        logic [31:0] a1;
        logic [5:0]  gh;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    bit    chk = 1'b0;
    int    compared = 0;
    int    mismatched = 0;
    exp_t  m_e;
    string m_nm;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard: sample requested with empty queue, got 0 entries, expected 1");
            end else begin
                m_e  = exp_q.pop_front();
                m_nm = name_q.pop_front();
                if (!m_e.sel) begin
                    cmp(m_nm, "hit0", {31'd0, lk0_hit}, {31'd0, m_e.h0});
                    cmp(m_nm, "taken0", {31'd0, lk0_taken}, {31'd0, m_e.t0});
                    cmp(m_nm, "target0", lk0_target, m_e.a0);
                    cmp(m_nm, "hit1", {31'd0, lk1_hit}, {31'd0, m_e.h1});
                    cmp(m_nm, "taken1", {31'd0, lk1_taken}, {31'd0, m_e.t1});
                    cmp(m_nm, "target1", lk1_target, m_e.a1);
                    cmp(m_nm, "ghr", {26'd0, ghr}, {26'd0, m_e.gh});
                end else begin
                    cmp(m_nm, "hit0", {31'd0, g_lk0_hit}, {31'd0, m_e.h0});
                    cmp(m_nm, "taken0", {31'd0, g_lk0_taken}, {31'd0, m_e.t0});
                    cmp(m_nm, "target0", g_lk0_target, m_e.a0);
                    cmp(m_nm, "hit1", {31'd0, g_lk1_hit}, {31'd0, m_e.h1});
                    cmp(m_nm, "taken1", {31'd0, g_lk1_taken}, {31'd0, m_e.t1});
                    cmp(m_nm, "target1", g_lk1_target, m_e.a1);
                    cmp(m_nm, "ghr", {26'd0, g_ghr}, {26'd0, m_e.gh});
                end
            end
        end
    end

    task automatic expect_lk(input bit sel, input string nm,
                             input logic h0, input logic t0, input logic [31:0] a0,
                             input logic h1, input logic t1, input logic [31:0] a1,
                             input logic [5:0] gh);
        exp_t e;
        e.sel = sel; e.h0 = h0; e.t0 = t0; e.a0 = a0;
        e.h1 = h1; e.t1 = t1; e.a1 = a1; e.gh = gh;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    task automatic main_upd(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt);
        upd_valid = 1'b1; upd_pc = pc; upd_is_jump = j; upd_taken = t; upd_target = tgt; upd_ghr = 6'd0;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic g_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic [5:0] gh);
        g_upd_valid = 1'b1; g_upd_pc = pc; g_upd_is_jump = 1'b0; g_upd_taken = t;
        g_upd_target = tgt; g_upd_ghr = gh;
        tick();
        g_upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        lk0_pc = '0; lk1_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_ghr = '0; inv_all = 1'b0;
        g_lk0_pc = '0; g_lk1_pc = '0; g_upd_valid = 1'b0; g_upd_pc = '0; g_upd_is_jump = 1'b0;
        g_upd_taken = 1'b0; g_upd_target = '0; g_upd_ghr = '0; g_inv_all = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        lk0_pc = 32'h8000_0010; lk1_pc = 32'h8000_0010;
        expect_lk(0, "reset", 0, 0, 0, 0, 0, 0, 6'h00);
        tick();

        // Update is not visible in its own cycle
        lk1_pc = 32'h8000_0110;
        expect_lk(0, "no_bypass", 0, 0, 0, 0, 0, 0, 6'h00);
        main_upd(32'h8000_0010, 1, 1, 32'h8000_0100);
        expect_lk(0, "jal_hit", 1, 1, 32'h8000_0100, 0, 0, 0, 6'h00);
        tick();

        main_upd(32'h8000_0020, 0, 1, 32'h8000_0400);
        lk0_pc = 32'h8000_0020; lk1_pc = 32'h8000_0020;
        expect_lk(0, "br_taken1", 1, 1, 32'h8000_0400, 1, 1, 32'h8000_0400, 6'h01);
        tick();
        main_upd(32'h8000_0020, 0, 0, 32'h0);
        expect_lk(0, "br_nt1", 1, 0, 32'h8000_0400, 1, 0, 32'h8000_0400, 6'h02);
        tick();
        main_upd(32'h8000_0020, 0, 0, 32'h0);
        main_upd(32'h8000_0020, 0, 0, 32'h0);
        expect_lk(0, "br_sat0", 1, 0, 32'h8000_0400, 1, 0, 32'h8000_0400, 6'h08);
        tick();
        main_upd(32'h8000_0020, 0, 1, 32'h8000_0400);
        expect_lk(0, "br_ctr1", 1, 0, 32'h8000_0400, 1, 0, 32'h8000_0400, 6'h11);
        tick();

        for (int i = 0; i < 4; i++) main_upd(32'h8000_0030, 0, 1, 32'h8000_0500);
        main_upd(32'h8000_0030, 0, 0, 32'h0);
        lk0_pc = 32'h8000_0030; lk1_pc = 32'h8000_0010;
        expect_lk(0, "ctr_sat3", 1, 1, 32'h8000_0500, 1, 1, 32'h8000_0100, 6'h3E);
        tick();

        inv_all = 1'b1;
        main_upd(32'h8000_0040, 0, 1, 32'h8000_0600);
        inv_all = 1'b0;
        lk0_pc = 32'h8000_0040;
        expect_lk(0, "inv_all", 0, 0, 0, 0, 0, 0, 6'h3D);
        tick();
        // Counter was bumped under inv_all: 2->3 then 3->2 still predicts taken
        main_upd(32'h8000_0040, 0, 1, 32'h8000_0600);
        main_upd(32'h8000_0040, 0, 0, 32'h0);
        expect_lk(0, "inv_pht_kept", 1, 1, 32'h8000_0600, 0, 0, 0, 6'h36);
        tick();

        rst = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h8000_0050; upd_is_jump = 1'b0; upd_taken = 1'b1;
        upd_target = 32'h8000_0700;
        tick();
        rst = 1'b0; upd_valid = 1'b0;
        lk0_pc = 32'h8000_0050; lk1_pc = 32'h8000_0040;
        expect_lk(0, "rst_drop", 0, 0, 0, 0, 0, 0, 6'h00);
        tick();

        main_upd(32'h8000_0060, 0, 0, 32'h0);
        lk0_pc = 32'h8000_0060; lk1_pc = 32'h8000_0020;
        expect_lk(0, "nt_no_alloc", 0, 0, 0, 0, 0, 0, 6'h00);
        tick();

        // Gshare: pc 0x8000_0000 with history 5 trains counter 5
        g_lk0_pc = 32'h8000_0000; g_lk1_pc = 32'h8000_0000;
        expect_lk(1, "g_reset", 0, 0, 0, 0, 0, 0, 6'h00);
        tick();
        g_upd(32'h8000_0000, 1, 32'h8000_0200, 6'h05);
        g_upd(32'h8000_0000, 1, 32'h8000_0200, 6'h05);
        g_upd(32'h8000_0080, 0, 32'h8000_0300, 6'h00);
        g_upd(32'h8000_0080, 0, 32'h8000_0300, 6'h00);
        g_upd(32'h8000_0080, 0, 32'h8000_0300, 6'h00);
        g_upd(32'h8000_0080, 1, 32'h8000_0300, 6'h00);
        g_upd(32'h8000_0080, 0, 32'h8000_0300, 6'h00);
        g_upd(32'h8000_0080, 1, 32'h8000_0300, 6'h00);
        expect_lk(1, "g_hist5", 1, 1, 32'h8000_0200, 1, 1, 32'h8000_0200, 6'h05);
        tick();
        for (int i = 0; i < 6; i++) g_upd(32'h8000_0080, 0, 32'h0, 6'h00);
        expect_lk(1, "g_hist0", 1, 0, 32'h8000_0200, 1, 0, 32'h8000_0200, 6'h00);
        tick();

        tick();
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_bpu_bimodal_btb

`default_nettype wire
